// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the RV32 core.
//
// Owns the program counter, issues one-word reads to imem (1-cycle read
// latency), and hands each fetched instruction with its PC to decode over a
// valid/ready handshake. Execute can redirect the PC; a misaligned redirect
// target or a PC outside the imem window halts fetch until reset.
//
// Ports
//   clk             core clock, rising edge
//   rst             asynchronous active-low reset
//   imem_en         imem read enable
//   imem_addr       imem byte address (holds its last value while idle)
//   imem_instr      imem read data, valid the cycle after imem_en
//   redirect_valid  branch/jump taken (single-cycle pulse)
//   redirect_pc     redirect target
//   out_valid       out_pc/out_instr carry a fetched instruction
//   out_ready       decode accepts the instruction this cycle
//   out_pc          PC of out_instr
//   out_instr       fetched instruction (0 when out_valid=0)
//   fetch_fault     sticky illegal-fetch-address flag
//   fault_pc        offending address while fetch_fault=1
//
// state | meaning
// BOOT  | first cycle after reset release; nothing issued
// RUN   | normal fetch
// HALT  | fault seen; no more issues, left only through reset

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC         = 32'h0100_0000,
   parameter logic [31:0] IMEM_BASE        = 32'h0100_0000,
   parameter int unsigned IMEM_DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        fetch_fault,
   output logic [31:0] fault_pc
);

   // One bit wider than the PC so a window ending at 2^32 still compares correctly.
   localparam logic [32:0] IMEM_LIMIT = {1'b0, IMEM_BASE} + (33'(IMEM_DEPTH_WORDS) << 2);

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_HALT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        fresh_q, fresh_d;
   logic [31:0] hold_q, hold_d;
   logic        fault_q, fault_d;
   logic [31:0] fault_pc_q, fault_pc_d;

   logic stalled;
   logic pc_legal;
   logic issue;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_BOOT;
         pc_q        <= RESET_PC;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         out_pc_q    <= '0;
         fresh_q     <= 1'b0;
         hold_q      <= '0;
         fault_q     <= 1'b0;
         fault_pc_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         out_pc_q    <= out_pc_d;
         fresh_q     <= fresh_d;
         hold_q      <= hold_d;
         fault_q     <= fault_d;
         fault_pc_q  <= fault_pc_d;
      end
   end

   always_comb begin
      stalled  = out_valid_q && !out_ready;
      pc_legal = (pc_q >= IMEM_BASE) && ({1'b0, pc_q} < IMEM_LIMIT);
      issue    = (state_q == ST_RUN) && !redirect_valid && !stalled && pc_legal;

      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      out_valid_d = stalled;
      out_pc_d    = out_pc_q;
      fresh_d     = fresh_q;
      hold_d      = hold_q;
      fault_d     = fault_q;
      fault_pc_d  = fault_pc_q;

      // imem returns data for one cycle only; park it before it drops to 0.
      if (stalled && fresh_q) begin
         hold_d  = imem_instr;
         fresh_d = 1'b0;
      end

      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (!redirect_valid && !pc_legal) begin
               state_d    = ST_HALT;
               fault_d    = 1'b1;
               fault_pc_d = pc_q;
            end
         end
         default: state_d = ST_HALT;
      endcase

      if (redirect_valid && (state_q != ST_HALT)) begin
         out_valid_d = 1'b0;
         if (redirect_pc[1:0] != 2'b00) begin
            state_d    = ST_HALT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
         end else begin
            state_d = ST_RUN;
            pc_d    = redirect_pc;
         end
      end

      if (issue) begin
         pc_d        = pc_q + 32'd4;
         addr_d      = pc_q;
         out_valid_d = 1'b1;
         out_pc_d    = pc_q;
         fresh_d     = 1'b1;
      end
   end

   assign imem_en     = issue;
   assign imem_addr   = issue ? pc_q : addr_q;
   assign out_valid   = out_valid_q;
   assign out_pc      = out_pc_q;
   assign out_instr   = !out_valid_q ? 32'd0 : (fresh_q ? imem_instr : hold_q);
   assign fetch_fault = fault_q;
   assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector tables for the listed scenarios,
// hand sequences for reset and the end-of-window fault, then random traffic
// checked against a transaction-level model of the fetch stage.
module tb_if_fetch_unit;

   localparam logic [31:0] R = 32'h0100_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_ready = 1'b1;

   logic        imem_en, imem_en4;
   logic [31:0] imem_addr, imem_addr4;
   logic [31:0] imem_instr = '0, imem_instr4 = '0;
   logic        out_valid, out_valid4;
   logic [31:0] out_pc, out_pc4, out_instr, out_instr4;
   logic        fetch_fault, fetch_fault4;
   logic [31:0] fault_pc, fault_pc4;

   logic [31:0] mem [0:1023];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk(clk), .rst(rst),
      .imem_en(imem_en), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr),
      .fetch_fault(fetch_fault), .fault_pc(fault_pc)
   );

   if_fetch_unit #(.IMEM_DEPTH_WORDS(4)) dut4 (
      .clk(clk), .rst(rst),
      .imem_en(imem_en4), .imem_addr(imem_addr4), .imem_instr(imem_instr4),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid4), .out_ready(out_ready),
      .out_pc(out_pc4), .out_instr(out_instr4),
      .fetch_fault(fetch_fault4), .fault_pc(fault_pc4)
   );

   // imem: synchronous read, zero when not enabled
   always_ff @(posedge clk) begin
      imem_instr  <= imem_en  ? mem[imem_addr[11:2]]  : 32'd0;
      imem_instr4 <= imem_en4 ? mem[imem_addr4[11:2]] : 32'd0;
   end

   typedef struct {
      logic        rv;
      logic [31:0] rp;
      logic        rdy;
      logic        en;
      logic [31:0] addr;
      logic        ov;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        flt;
      logic [31:0] fpc;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge: drive, settle, compare, advance to the next negedge.
   task automatic apply_vec(input vec_t v, input bit use4);
      redirect_valid = v.rv;
      redirect_pc    = v.rp;
      out_ready      = v.rdy;
      #1;
      if (!use4) begin
         chk("imem_en", 32'(imem_en), 32'(v.en));
         if (v.en) chk("imem_addr", imem_addr, v.addr);
         chk("out_valid", 32'(out_valid), 32'(v.ov));
         if (v.ov) chk("out_pc", out_pc, v.pc);
         chk("out_instr", out_instr, v.instr);
         chk("fetch_fault", 32'(fetch_fault), 32'(v.flt));
         chk("fault_pc", fault_pc, v.fpc);
      end else begin
         chk("d4_imem_en", 32'(imem_en4), 32'(v.en));
         if (v.en) chk("d4_imem_addr", imem_addr4, v.addr);
         chk("d4_out_valid", 32'(out_valid4), 32'(v.ov));
         if (v.ov) chk("d4_out_pc", out_pc4, v.pc);
         chk("d4_out_instr", out_instr4, v.instr);
         chk("d4_fetch_fault", 32'(fetch_fault4), 32'(v.flt));
         chk("d4_fault_pc", fault_pc4, v.fpc);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   function automatic vec_t mk(input logic rv, input logic [31:0] rp, input logic rdy,
                               input logic en, input logic [31:0] addr, input logic ov,
                               input logic [31:0] pc, input logic [31:0] instr,
                               input logic flt, input logic [31:0] fpc);
      vec_t v;
      v.rv = rv; v.rp = rp; v.rdy = rdy; v.en = en; v.addr = addr;
      v.ov = ov; v.pc = pc; v.instr = instr; v.flt = flt; v.fpc = fpc;
      return v;
   endfunction

   // Transaction-level reference model
   logic [31:0] m_pc, m_opc, m_fpc;
   bit          m_boot, m_halt, m_ov, m_flt;

   function automatic bit in_window(input logic [31:0] a);
      return (longint'(a) >= longint'(R)) && (longint'(a) < longint'(R) + 4096);
   endfunction

   task automatic model_reset();
      m_pc = R; m_opc = '0; m_fpc = '0;
      m_boot = 1; m_halt = 0; m_ov = 0; m_flt = 0;
   endtask

   task automatic model_cycle(input logic rv, input logic [31:0] rp, input logic rdy);
      bit stall, exp_en, nov;
      redirect_valid = rv;
      redirect_pc    = rp;
      out_ready      = rdy;
      #1;
      stall  = m_ov && !rdy;
      exp_en = !m_boot && !m_halt && !rv && !stall && in_window(m_pc);
      chk("rnd_imem_en", 32'(imem_en), 32'(exp_en));
      if (exp_en) chk("rnd_imem_addr", imem_addr, m_pc);
      chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) chk("rnd_out_pc", out_pc, m_opc);
      chk("rnd_out_instr", out_instr, m_ov ? mem[m_opc[11:2]] : 32'd0);
      chk("rnd_fetch_fault", 32'(fetch_fault), 32'(m_flt));
      chk("rnd_fault_pc", fault_pc, m_flt ? m_fpc : 32'd0);
      nov = stall;
      if (!m_halt && rv) begin
         nov = 0;
         if (rp[1:0] != 2'b00) begin
            m_halt = 1; m_flt = 1; m_fpc = rp;
         end else begin
            m_pc = rp;
         end
         m_boot = 0;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (!m_halt && !in_window(m_pc)) begin
         m_halt = 1; m_flt = 1; m_fpc = m_pc;
      end else if (exp_en) begin
         nov = 1; m_opc = m_pc; m_pc = m_pc + 32'd4;
      end
      m_ov = nov;
      @(negedge clk);
   endtask

   vec_t tbl_main[$];
   vec_t tbl_d4[$];

   initial begin
      int halt_cnt;
      logic [31:0] tgt;

      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0] = 32'h0010_0093;
      mem[1] = 32'h0020_0113;
      mem[2] = 32'h0020_80b3;
      mem[3] = 32'hffdf_f06f;

      //                rv rp      rdy en addr   ov pc     instr           flt fpc
      tbl_main.push_back(mk(0, 0,      1, 0, 0,     0, 0,     0,             0, 0));
      tbl_main.push_back(mk(0, 0,      1, 1, R,     0, 0,     0,             0, 0));
      tbl_main.push_back(mk(0, 0,      1, 1, R+4,   1, R,     32'h00100093,  0, 0));
      tbl_main.push_back(mk(0, 0,      0, 0, 0,     1, R+4,   32'h00200113,  0, 0));
      tbl_main.push_back(mk(0, 0,      0, 0, 0,     1, R+4,   32'h00200113,  0, 0));
      tbl_main.push_back(mk(0, 0,      0, 0, 0,     1, R+4,   32'h00200113,  0, 0));
      tbl_main.push_back(mk(0, 0,      1, 1, R+8,   1, R+4,   32'h00200113,  0, 0));
      tbl_main.push_back(mk(0, 0,      1, 1, R+12,  1, R+8,   32'h002080b3,  0, 0));
      tbl_main.push_back(mk(1, R,      1, 0, 0,     1, R+12,  32'hffdff06f,  0, 0));
      tbl_main.push_back(mk(0, 0,      1, 1, R,     0, 0,     0,             0, 0));
      tbl_main.push_back(mk(0, 0,      1, 1, R+4,   1, R,     32'h00100093,  0, 0));
      tbl_main.push_back(mk(1, R+6,    1, 0, 0,     1, R+4,   32'h00200113,  0, 0));
      tbl_main.push_back(mk(0, 0,      1, 0, 0,     0, 0,     0,             1, R+6));
      tbl_main.push_back(mk(0, 0,      1, 0, 0,     0, 0,     0,             1, R+6));

      tbl_d4.push_back(mk(0, 0, 1, 0, 0,    0, 0,    0,            0, 0));
      tbl_d4.push_back(mk(0, 0, 1, 1, R,    0, 0,    0,            0, 0));
      tbl_d4.push_back(mk(0, 0, 1, 1, R+4,  1, R,    32'h00100093, 0, 0));
      tbl_d4.push_back(mk(0, 0, 1, 1, R+8,  1, R+4,  32'h00200113, 0, 0));
      tbl_d4.push_back(mk(0, 0, 1, 1, R+12, 1, R+8,  32'h002080b3, 0, 0));
      tbl_d4.push_back(mk(0, 0, 1, 0, 0,    1, R+12, 32'hffdff06f, 0, 0));
      tbl_d4.push_back(mk(0, 0, 1, 0, 0,    0, 0,    0,            1, R+16));
      tbl_d4.push_back(mk(0, 0, 1, 0, 0,    0, 0,    0,            1, R+16));

      // reset state
      #2;
      chk("rst_imem_en", 32'(imem_en), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_fault_pc", fault_pc, 32'd0);

      do_reset();
      foreach (tbl_main[i]) apply_vec(tbl_main[i], 1'b0);

      // asynchronous reset clears a sticky fault at once
      #1;
      rst = 1'b0;
      #1;
      chk("async_rst_fault", 32'(fetch_fault), 32'd0);
      chk("async_rst_fault_pc", fault_pc, 32'd0);

      // reset mid-stall with out_valid=1, then restart from RESET_PC
      do_reset();
      apply_vec(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      apply_vec(mk(0, 0, 1, 1, R, 0, 0, 0, 0, 0), 1'b0);
      apply_vec(mk(0, 0, 0, 0, 0, 1, R, 32'h00100093, 0, 0), 1'b0);
      #1;
      chk("stall_pre_valid", 32'(out_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("stall_rst_valid", 32'(out_valid), 32'd0);
      chk("stall_rst_en", 32'(imem_en), 32'd0);
      chk("stall_rst_fault", 32'(fetch_fault), 32'd0);
      chk("stall_rst_instr", out_instr, 32'd0);
      @(negedge clk);
      out_ready = 1'b1;
      rst = 1'b1;
      apply_vec(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      apply_vec(mk(0, 0, 1, 1, R, 0, 0, 0, 0, 0), 1'b0);
      apply_vec(mk(0, 0, 1, 1, R+4, 1, R, 32'h00100093, 0, 0), 1'b0);

      // last legal word fetched, next address faults, pending output drains
      do_reset();
      foreach (tbl_d4[i]) apply_vec(tbl_d4[i], 1'b1);

      // random traffic against the model
      do_reset();
      model_reset();
      halt_cnt = 0;
      for (int c = 0; c < 4000; c++) begin
         if (m_halt) halt_cnt++;
         if (halt_cnt > 4) begin
            do_reset();
            model_reset();
            halt_cnt = 0;
         end
         case ($urandom_range(0, 3))
            0: tgt = R + 32'(4 * $urandom_range(0, 1023));
            1: tgt = R + 32'(4 * $urandom_range(1020, 1023));
            2: tgt = R + 32'($urandom_range(0, 4095));
            default: tgt = $urandom & 32'hFFFF_FFFC;
         endcase
         model_cycle(($urandom_range(0, 15) == 0), tgt, ($urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
